// File: rtl/mul4_issue_ctrl.sv
// mul4_issue_ctrl: operand-issue and result-capture stage for the 4x4
// sequential shift-add multiplier core.
//
// Accepts an operand pair, drives the core's A/B inputs with a one-cycle
// START, waits for the core's READY (ignoring it on the first WAIT cycle),
// captures the product and offers it on a result port. A wait counter aborts
// the operation with RES_ERR=1 when the core never answers.
//
// Optional feature, enabled by defining MUL4_ACC_EN: a running accumulator
// (ACC, ACC_W bits, wrapping) of all successfully transferred products,
// cleared by ACC_CLR. Without the macro the ACC/ACC_CLR ports do not exist.
//
// Handshakes: an operand pair transfers on a rising CK edge where
// OP_VALID && OP_READY; a result transfers on a rising CK edge where
// RES_VALID && RES_READY. While RES_VALID is high and RES_READY is low,
// RES_P and RES_ERR are held stable. OP_READY is high only in IDLE.
//
// dbg_state exposes the FSM state (0 IDLE, 1 LOAD, 2 WAIT, 3 DONE).

module mul4_issue_ctrl #(
    parameter int TIMEOUT_CYC = 16
`ifdef MUL4_ACC_EN
    ,
    parameter int ACC_W = 12
`endif
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [3:0]       OP_A,
    input  logic [3:0]       OP_B,
    output logic [3:0]       MUL_A,
    output logic [3:0]       MUL_B,
    output logic             MUL_START,
    input  logic [7:0]       MUL_P,
    input  logic             MUL_READY,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [7:0]       RES_P,
    output logic             RES_ERR,
    output logic             BUSY,
    output logic [1:0]       dbg_state
`ifdef MUL4_ACC_EN
    ,
    input  logic             ACC_CLR,
    output logic [ACC_W-1:0] ACC
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last counter value of WAIT; reaching it without a capture aborts.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    assign dbg_state = state;

    // Issue/capture FSM; every output is a register updated here.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            OP_READY  <= 1'b0;
            MUL_A     <= 4'd0;
            MUL_B     <= 4'd0;
            MUL_START <= 1'b0;
            RES_VALID <= 1'b0;
            RES_P     <= 8'd0;
            RES_ERR   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    OP_READY <= 1'b1;
                    if (OP_VALID && OP_READY) begin
                        // Operands stay latched until the next acceptance so
                        // the core sees stable B while it shifts.
                        MUL_A     <= OP_A;
                        MUL_B     <= OP_B;
                        MUL_START <= 1'b1;
                        OP_READY  <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    MUL_START <= 1'b0;
                    wait_cnt  <= 8'd0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // READY on the first WAIT cycle may be left over from the
                    // previous operation, so it is only trusted from count 1.
                    // Capture is tested first so it wins over the timeout.
                    if (wait_cnt != 8'd0 && MUL_READY) begin
                        RES_P     <= MUL_P;
                        RES_ERR   <= 1'b0;
                        RES_VALID <= 1'b1;
                        state     <= DONE;
                    end else if (wait_cnt >= CNT_LAST) begin
                        RES_P     <= 8'd0;
                        RES_ERR   <= 1'b1;
                        RES_VALID <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        BUSY      <= 1'b0;
                        OP_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MUL4_ACC_EN
    // Running sum of transferred, non-errored products; a clear in the same
    // cycle as a transfer is applied before the add.
    always_ff @(posedge CK) begin
        if (!RN) begin
            ACC <= '0;
        end else if (RES_VALID && RES_READY && !RES_ERR) begin
            ACC <= (ACC_CLR ? '0 : ACC) + {{(ACC_W-8){1'b0}}, RES_P};
        end else if (ACC_CLR) begin
            ACC <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_mul4_issue_ctrl.sv
// Self-checking bench for mul4_issue_ctrl with a behavioural core model.
// Define MUL4_ACC_EN to also exercise the accumulator.

module tb_mul4_issue_ctrl;

  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       OP_VALID = 1'b0;
  logic       OP_READY;
  logic [3:0] OP_A = 4'd0;
  logic [3:0] OP_B = 4'd0;
  logic [3:0] MUL_A;
  logic [3:0] MUL_B;
  logic       MUL_START;
  logic [7:0] MUL_P;
  logic       MUL_READY;
  logic       RES_VALID;
  logic       RES_READY = 1'b0;
  logic [7:0] RES_P;
  logic       RES_ERR;
  logic       BUSY;
  logic [1:0] dbg_state;
`ifdef MUL4_ACC_EN
  logic        ACC_CLR = 1'b0;
  logic [11:0] ACC;
`endif

  always #5 CK = ~CK;

  mul4_issue_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CK(CK), .RN(RN),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_A(OP_A), .OP_B(OP_B),
    .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_START(MUL_START),
    .MUL_P(MUL_P), .MUL_READY(MUL_READY),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_P(RES_P),
    .RES_ERR(RES_ERR), .BUSY(BUSY), .dbg_state(dbg_state)
`ifdef MUL4_ACC_EN
    , .ACC_CLR(ACC_CLR), .ACC(ACC)
`endif
  );

  // ---------------- core model ----------------
  // mode 0: READY drops on START and rises core_lat edges later, then stays high
  // mode 1: READY tied high; mode 2: READY tied low
  int         core_mode = 0;
  int         core_lat  = 5;
  logic       core_busy = 1'b0;
  logic [7:0] core_left = 8'd0;
  logic [7:0] core_p    = 8'd0;

  always @(posedge CK) begin
    if (MUL_START) begin
      core_p    <= {4'd0, MUL_A} * {4'd0, MUL_B};
      core_left <= 8'(core_lat);
      core_busy <= 1'b1;
    end else if (core_busy) begin
      if (core_left <= 8'd1) core_busy <= 1'b0;
      core_left <= core_left - 8'd1;
    end
  end

  assign MUL_P     = core_p;
  assign MUL_READY = (core_mode == 1) ? 1'b1 : (core_mode == 2) ? 1'b0 : !core_busy;

  // ---------------- reference model ----------------
  // WAIT cycle (0-based) on which the operation ends.
  function automatic int ref_end_w(input int mode, input int lat);
    if (mode == 1) return 1;
    if (mode == 2) return TIMEOUT_CYC - 1;
    if (lat > TIMEOUT_CYC - 1) return TIMEOUT_CYC - 1;
    return (lat < 1) ? 1 : lat;
  endfunction

  function automatic logic ref_err(input int mode, input int lat);
    return (mode == 2) || (mode == 0 && lat > TIMEOUT_CYC - 1);
  endfunction

  // Cycles from the START cycle to the first RES_VALID cycle.
  function automatic int ref_delay(input int mode, input int lat);
    return ref_end_w(mode, lat) + 2;
  endfunction

  // ---------------- scoreboard / counters ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         exp_d_q[$];

  // ---------------- driver ----------------
  logic [7:0] obs_p;
  logic       obs_err;
  int         obs_delay;
  int         obs_starts;
  bit         obs_ops_ok;
  bit         obs_hold_ok;
  bit         obs_oprdy_ok;
  bit         obs_after_ok;
  bit         obs_timeout;

  // Offers one pair, follows it to the result, holds RES_READY low for
  // 'hold' cycles, then takes the result. Starts and ends just after a negedge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input int hold, input bit clr_at_xfer);
    int guard;
    obs_ops_ok = 1; obs_hold_ok = 1; obs_oprdy_ok = 1; obs_after_ok = 0;
    obs_timeout = 0; obs_delay = 0; obs_starts = 0; obs_p = 8'hxx; obs_err = 1'bx;
    guard = 0;
    while (OP_READY !== 1'b1 && guard < 50) begin
      @(negedge CK); guard++;
    end
    if (OP_READY !== 1'b1) begin obs_timeout = 1; return; end
    OP_A = a; OP_B = b; OP_VALID = 1'b1;
    @(negedge CK);
    OP_VALID = 1'b0; OP_A = 4'($urandom); OP_B = 4'($urandom);
    while (RES_VALID !== 1'b1 && obs_delay < 300) begin
      if (MUL_START === 1'b1) obs_starts++;
      if (MUL_A !== a || MUL_B !== b) obs_ops_ok = 0;
      if (OP_READY !== 1'b0) obs_oprdy_ok = 0;
      @(negedge CK); obs_delay++;
    end
    if (RES_VALID !== 1'b1) begin obs_timeout = 1; return; end
    obs_p = RES_P; obs_err = RES_ERR;
    for (int i = 0; i < hold; i++) begin
      OP_VALID = 1'($urandom_range(0, 1)); OP_A = 4'($urandom); OP_B = 4'($urandom);
      @(negedge CK);
      if (RES_VALID !== 1'b1 || RES_P !== obs_p || RES_ERR !== obs_err) obs_hold_ok = 0;
      if (OP_READY !== 1'b0 || MUL_START !== 1'b0) obs_oprdy_ok = 0;
      if (MUL_A !== a || MUL_B !== b) obs_ops_ok = 0;
    end
    OP_VALID = 1'b0;
    RES_READY = 1'b1;
`ifdef MUL4_ACC_EN
    ACC_CLR = clr_at_xfer;
`else
    if (clr_at_xfer) obs_after_ok = 0;
`endif
    @(negedge CK);
    RES_READY = 1'b0;
`ifdef MUL4_ACC_EN
    ACC_CLR = 1'b0;
`endif
    obs_after_ok = (OP_READY === 1'b1 && RES_VALID === 1'b0 && BUSY === 1'b0 &&
                    MUL_A === a && MUL_B === b);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RN = 1'b0;
    @(negedge CK); @(negedge CK);
    checks++;
    if ({OP_READY, MUL_A, MUL_B, MUL_START, RES_VALID, RES_P, RES_ERR, BUSY} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b a=%h b=%h st=%b rv=%b p=%h err=%b busy=%b want all 0",
               OP_READY, MUL_A, MUL_B, MUL_START, RES_VALID, RES_P, RES_ERR, BUSY);
    end
`ifdef MUL4_ACC_EN
    checks++;
    if (ACC !== 12'd0) begin errors++; $display("FAIL reset_acc: got %h want 000", ACC); end
`endif
    RN = 1'b1;
    @(negedge CK);
    checks++;
    if (OP_READY !== 1'b1) begin
      errors++; $display("FAIL reset_op_ready_after: got %b want 1", OP_READY);
    end
  endtask

  task automatic test_basic();
    core_mode = 0; core_lat = 5;
    run_op(4'd5, 4'd3, 2, 1'b0);
    checks++;
    if (obs_timeout) begin errors++; $display("FAIL basic_progress: got stuck want result"); end
    checks++;
    if ({obs_err, obs_p} !== 9'h00F) begin
      errors++; $display("FAIL basic_result: got err=%b p=%h want err=0 p=0f", obs_err, obs_p);
    end
    checks++;
    if (obs_delay !== ref_delay(0, 5)) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", obs_delay, ref_delay(0, 5));
    end
    checks++;
    if (obs_starts !== 1) begin errors++; $display("FAIL basic_start_pulses: got %0d want 1", obs_starts); end
    checks++;
    if (!obs_after_ok) begin errors++; $display("FAIL basic_after_transfer: got 0 want 1"); end
  endtask

  task automatic test_extremes();
    core_mode = 0;
    core_lat = $urandom_range(2, 10);
    run_op(4'd15, 4'd15, 1, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h0E1) begin
      errors++; $display("FAIL extreme_15x15: got err=%b p=%h want err=0 p=e1", obs_err, obs_p);
    end
    checks++;
    if (!obs_ops_ok || obs_starts !== 1) begin
      errors++; $display("FAIL extreme_ops_stable: got ok=%b starts=%0d want 1/1", obs_ops_ok, obs_starts);
    end
    core_lat = $urandom_range(2, 10);
    run_op(4'd0, 4'd9, 0, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h000) begin
      errors++; $display("FAIL extreme_0x9: got err=%b p=%h want err=0 p=00", obs_err, obs_p);
    end
  endtask

  task automatic test_backpressure();
    core_mode = 0; core_lat = 3;
    run_op(4'd12, 4'd11, 10, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h084) begin
      errors++; $display("FAIL bp_result: got err=%b p=%h want err=0 p=84", obs_err, obs_p);
    end
    checks++;
    if (!obs_hold_ok) begin errors++; $display("FAIL bp_hold_stable: got 0 want 1"); end
    checks++;
    if (!obs_oprdy_ok || !obs_ops_ok) begin
      errors++; $display("FAIL bp_op_ignored: got rdy_ok=%b ops_ok=%b want 1/1", obs_oprdy_ok, obs_ops_ok);
    end
    checks++;
    if (!obs_after_ok) begin errors++; $display("FAIL bp_after_transfer: got 0 want 1"); end
  endtask

  task automatic test_stale_ready();
    core_mode = 1;
    run_op(4'd6, 4'd7, 0, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h02A) begin
      errors++; $display("FAIL stale_result: got err=%b p=%h want err=0 p=2a", obs_err, obs_p);
    end
    checks++;
    if (obs_delay !== ref_delay(1, 0)) begin
      errors++; $display("FAIL stale_latency: got %0d want %0d", obs_delay, ref_delay(1, 0));
    end
    core_mode = 0;
  endtask

  task automatic test_timeout();
    core_mode = 2;
    run_op(4'd9, 4'd9, 1, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h100) begin
      errors++; $display("FAIL timeout_result: got err=%b p=%h want err=1 p=00", obs_err, obs_p);
    end
    checks++;
    if (obs_delay !== ref_delay(2, 0)) begin
      errors++; $display("FAIL timeout_latency: got %0d want %0d", obs_delay, ref_delay(2, 0));
    end
    // READY arriving exactly on the last WAIT cycle: capture wins
    core_mode = 0; core_lat = TIMEOUT_CYC - 1;
    run_op(4'd4, 4'd13, 0, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h034 || obs_delay !== ref_delay(0, TIMEOUT_CYC - 1)) begin
      errors++; $display("FAIL timeout_edge_capture: got err=%b p=%h d=%0d want err=0 p=34 d=%0d",
                         obs_err, obs_p, obs_delay, ref_delay(0, TIMEOUT_CYC - 1));
    end
    // READY one cycle too late: timeout
    core_lat = TIMEOUT_CYC;
    run_op(4'd4, 4'd13, 0, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h100 || obs_delay !== ref_delay(0, TIMEOUT_CYC)) begin
      errors++; $display("FAIL timeout_edge_late: got err=%b p=%h d=%0d want err=1 p=00 d=%0d",
                         obs_err, obs_p, obs_delay, ref_delay(0, TIMEOUT_CYC));
    end
  endtask

  task automatic test_reset_mid_op();
    int guard;
    core_mode = 0; core_lat = 12;
    guard = 0;
    while (OP_READY !== 1'b1 && guard < 50) begin @(negedge CK); guard++; end
    OP_A = 4'd3; OP_B = 4'd3; OP_VALID = 1'b1;
    @(negedge CK);               // LOAD
    OP_VALID = 1'b0;
    @(negedge CK); @(negedge CK); @(negedge CK);   // WAIT
    RN = 1'b0;
    @(negedge CK);
    checks++;
    if ({BUSY, RES_VALID, MUL_START, OP_READY, MUL_A, MUL_B} !== 12'd0) begin
      errors++; $display("FAIL reset_mid_wait: got busy=%b rv=%b st=%b rdy=%b a=%h b=%h want all 0",
                         BUSY, RES_VALID, MUL_START, OP_READY, MUL_A, MUL_B);
    end
    RN = 1'b1;
    @(negedge CK);
    // reset during LOAD drops START on the same edge
    OP_A = 4'd1; OP_B = 4'd1; OP_VALID = 1'b1;
    @(negedge CK);
    OP_VALID = 1'b0;
    RN = 1'b0;
    @(negedge CK);
    checks++;
    if ({MUL_START, BUSY} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_load: got st=%b busy=%b want 0/0", MUL_START, BUSY);
    end
    RN = 1'b1;
    core_lat = 4;
    run_op(4'd2, 4'd7, 0, 1'b0);
    checks++;
    if (obs_timeout || {obs_err, obs_p} !== 9'h00E || obs_starts !== 1) begin
      errors++; $display("FAIL reset_then_2x7: got err=%b p=%h starts=%0d want err=0 p=0e starts=1",
                         obs_err, obs_p, obs_starts);
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    logic [8:0] exp_v;
    int         exp_d;
    int         mode, lat;
    for (int n = 0; n < 24; n++) begin
      a = 4'($urandom); b = 4'($urandom);
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      lat = $urandom_range(1, TIMEOUT_CYC + 3);
      core_mode = mode; core_lat = lat;
      exp_q.push_back({ref_err(mode, lat), ref_err(mode, lat) ? 8'd0 : 8'(a * b)});
      exp_d_q.push_back(ref_delay(mode, lat));
      run_op(a, b, $urandom_range(0, 3), 1'b0);
      exp_v = exp_q.pop_front();
      exp_d = exp_d_q.pop_front();
      checks++;
      if (obs_timeout || {obs_err, obs_p} !== exp_v) begin
        errors++; $display("FAIL random_result[%0d] %0hx%0h lat=%0d: got err=%b p=%h want err=%b p=%h",
                           n, a, b, lat, obs_err, obs_p, exp_v[8], exp_v[7:0]);
      end
      checks++;
      if (obs_delay !== exp_d || obs_starts !== 1 || !obs_ops_ok || !obs_hold_ok || !obs_after_ok) begin
        errors++; $display("FAIL random_protocol[%0d]: got d=%0d starts=%0d ops=%b hold=%b after=%b want d=%0d 1 1 1 1",
                           n, obs_delay, obs_starts, obs_ops_ok, obs_hold_ok, obs_after_ok, exp_d);
      end
    end
    core_mode = 0;
  endtask

`ifdef MUL4_ACC_EN
  task automatic test_acc();
    ACC_CLR = 1'b1;
    @(negedge CK);
    ACC_CLR = 1'b0;
    checks++;
    if (ACC !== 12'd0) begin errors++; $display("FAIL acc_clear_idle: got %h want 000", ACC); end
    core_mode = 0;
    for (int i = 0; i < 3; i++) begin
      core_lat = $urandom_range(1, 8);
      run_op(4'd15, 4'd15, $urandom_range(0, 2), 1'b0);
    end
    checks++;
    if (ACC !== 12'h2A3) begin errors++; $display("FAIL acc_sum3: got %h want 2a3", ACC); end
    core_lat = 3;
    run_op(4'd3, 4'd5, 1, 1'b1);
    checks++;
    if (ACC !== 12'h00F) begin errors++; $display("FAIL acc_clear_with_add: got %h want 00f", ACC); end
    core_mode = 2;
    run_op(4'd7, 4'd7, 0, 1'b0);
    checks++;
    if (ACC !== 12'h00F) begin errors++; $display("FAIL acc_error_skipped: got %h want 00f", ACC); end
    core_mode = 0;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_stale_ready();
    test_timeout();
    test_reset_mid_op();
    test_random();
`ifdef MUL4_ACC_EN
    test_acc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul4_issue_ctrl.md
Name: mul4_issue_ctrl

Overview:
Operand-issue and result-capture stage placed directly in front of the 4x4 sequential shift-add multiplier core.
- Accepts operand pairs over a valid/ready handshake.
- Drives the core's A/B operand inputs and a one-cycle START.
- Waits for the core's READY, captures the 8-bit product and presents it on a valid/ready result port.
- Provides the core with stable operands and clean START pulses, and gives the rest of the system a flow-controlled interface with timeout protection.

Parameters:
TIMEOUT_CYC, 16, cycles spent in WAIT without a MUL_READY sample before the operation is aborted with error (legal range 4..255)
ACC_W, 12, accumulator width when MUL4_ACC_EN is defined (minimum 8)

Ports:
CK  in  1  clock; all state updates on rising edge
RN  in  1  reset, synchronous, active-low
OP_VALID  in  1  operand pair offered
OP_READY  out  1  controller can accept an operand pair
OP_A  in  4  multiplicand
OP_B  in  4  multiplier
MUL_A  out  4  to core A3..A0
MUL_B  out  4  to core B3..B0
MUL_START  out  1  to core START
MUL_P  in  8  from core P7..P0
MUL_READY  in  1  from core READY
RES_VALID  out  1  result available
RES_READY  in  1  consumer takes result
RES_P  out  8  captured product
RES_ERR  out  1  result aborted by timeout; qualified by RES_VALID
BUSY  out  1  state is not IDLE
ACC_CLR  in  1  accumulator clear (MUL4_ACC_EN only)
ACC  out  ACC_W  running sum of products (MUL4_ACC_EN only)

Behaviour:
- Reset is synchronous: RN=0 sampled at a CK edge applies reset on that edge.
- Reset values:
  - state IDLE
  - OP_READY=0 while RN=0, then 1 from the first cycle after RN=1
  - MUL_A=0, MUL_B=0, MUL_START=0
  - RES_VALID=0, RES_P=0, RES_ERR=0, BUSY=0, ACC=0
- States: IDLE, LOAD, WAIT, DONE. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - OP_READY=1.
  - On OP_VALID=1: latch OP_A→MUL_A and OP_B→MUL_B, then go to LOAD.
- LOAD:
  - Exactly one cycle; MUL_START=1.
  - Wait counter cleared to 0; go to WAIT.
- WAIT:
  - MUL_START=0; counter increments every cycle.
  - MUL_READY is ignored while counter=0 (guard cycle, so a stale READY from the previous operation is not captured).
  - First cycle with counter>=1 and MUL_READY=1: RES_P<=MUL_P, RES_ERR<=0, go to DONE.
  - Counter reaching TIMEOUT_CYC-1 without capture: RES_P<=0, RES_ERR<=1, go to DONE.
  - If a capture and the timeout fall on the same cycle, the capture wins.
- DONE:
  - RES_VALID=1; RES_P and RES_ERR held stable until transfer.
  - On RES_READY=1: RES_VALID<=0 on the next edge and go to IDLE.
  - No back-to-back bypass: minimum issue interval is LOAD + WAIT(>=2) + DONE + IDLE.
- MUL_A/MUL_B stay constant from acceptance until the next acceptance. The core samples B during shifting, so operands must not change mid-operation.
- OP_READY=0 in LOAD, WAIT and DONE. OP_VALID outside IDLE is ignored, with no side effect.
- Reset mid-operation (any state): immediate return to reset values, the pending result is dropped, and MUL_START is deasserted on the same edge.
- RES_READY while RES_VALID=0 has no effect.

Optional Feature:
MUL4_ACC_EN
- Defined:
  - On each successful result transfer (RES_VALID & RES_READY & !RES_ERR), ACC <= ACC + zero-extended RES_P, modulo 2^ACC_W (wrap, no saturation).
  - Errored results are not added.
  - ACC_CLR=1 sets ACC to 0 on the next edge. If a transfer occurs in the same cycle, ACC <= RES_P; the clear applies first, then the add.
- Not defined: the ACC and ACC_CLR ports are absent and there is no accumulator logic.

Test Plan:
- Basic: reset, then OP_A=5, OP_B=3 accepted; the core model raises READY after 5 cycles → one MUL_START pulse; RES_VALID with RES_P=0x0F, RES_ERR=0; OP_READY returns to 1 the cycle after the transfer.
- Extremes: 15x15 → RES_P=0xE1; 0x9 → RES_P=0x00; MUL_A/MUL_B constant through WAIT; MUL_START asserted for exactly 1 cycle per operation.
- Backpressure: RES_READY held 0 for 10 cycles → RES_VALID=1 and RES_P stable throughout; OP_VALID pulses during that window not accepted (OP_READY=0).
- Stale READY: MUL_READY tied high → capture occurs on the second WAIT cycle, never the first; timeout: MUL_READY tied low, TIMEOUT_CYC=16 → RES_VALID with RES_ERR=1, RES_P=0x00 after 16 WAIT cycles.
- Reset mid-WAIT: RN=0 for 1 cycle → next cycle BUSY=0, RES_VALID=0, MUL_START=0; a new operation 2x7 afterwards → RES_P=0x0E.
- MUL4_ACC_EN: results 0xE1, 0xE1, 0xE1 → ACC=0x2A3; then ACC_CLR together with a 0x0F transfer → ACC=0x00F; a timeout result leaves ACC unchanged.
